adder_pipe: RTL and testbench
=============================

// Module: adder_pipe
// PURPOSE
//  Parametrised, pipelined add/subtract unit; successor to the 8-bit ripple adder.
//  Splits a WIDTH-bit operation into STAGES slices, one slice per cycle; carry is registered between slices.
//  valid/ready handshake on both sides. Feeds datapath accumulators and ALU blocks.
// PARAMETERS
//  WIDTH   32  operand/result width; must be a multiple of STAGES (elaboration $error otherwise)
//  STAGES   4  pipeline depth = number of slices; SLICE = WIDTH/STAGES bits per slice; STAGES>=1
// PORTS
//  clk        in   1       rising-edge clock; the block's only clock
//  reset      in   1       synchronous, active-high reset
//  in_valid   in   1       a/b/op/cin valid this cycle
//  in_ready   out  1       block accepts input; transfer when in_valid & in_ready
//  a          in   WIDTH   operand A (unsigned or two's-complement)
//  b          in   WIDTH   operand B
//  op         in   1       0 = ADD, 1 = SUB
//  cin        in   1       ADD: carry-in; SUB: borrow-in
//  out_valid  out  1       sum/c_out/ovf valid
//  out_ready  in   1       consumer accepts; transfer when out_valid & out_ready
//  sum        out  WIDTH   result
//  c_out      out  1       carry out of bit WIDTH-1; SUB: 1 = no borrow
//  ovf        out  1       signed overflow
// BEHAVIOUR
//  Arithmetic: ADD {c_out,sum} = a + b + cin.
//   SUB {c_out,sum} = a + ~b + ~cin, i.e. a - b - cin, all modulo 2^WIDTH.
//  ovf = (A[W-1] == B'[W-1]) & (sum[W-1] != A[W-1]); B' = b for ADD, ~b for SUB.
//  Pipeline: stage k (0..STAGES-1) adds slice k of A and B' plus the carry from stage k-1
//   (stage 0 uses the effective carry-in). Each stage registers its valid bit, carry,
//   the accumulated low result bits and the not-yet-used upper operand bits.
//  Latency: exactly STAGES cycles from input acceptance to out_valid when no stall occurs.
//  Throughput: one operation per cycle.
//  Stall: stall = out_valid & ~out_ready.
//   in_ready = ~stall; combinational from out_ready, no other path.
//   During a stall every stage holds its contents, bubbles included; no bubble collapsing.
//  Ordering: results leave in acceptance order; no drops, no duplicates.
//  Outputs sum/c_out/ovf hold stable while out_valid & ~out_ready.
//  Outputs are don't-care while ~out_valid, but sum/c_out/ovf are 0 after reset.
//  Reset: all stage valid bits clear; out_valid=0, sum=0, c_out=0, ovf=0.
//   in_ready=1 in the first cycle after reset.
//   Reset mid-operation discards all in-flight operations; no partial result is emitted.
//  Simultaneous accept and emit in the same cycle is legal and required at full throughput.
//  Wrap-around: 8'hFF + 8'h01 -> sum 8'h00, c_out 1. No saturation.
//  STAGES==1: a single registered WIDTH-bit add; latency 1.
// STRUCTURE
//  Package adder_pkg:
//   typedef enum logic {OP_ADD=1'b0, OP_SUB=1'b1} add_op_e
//   localparam function for SLICE width and the WIDTH%STAGES check.
//  Sub-module add_slice #(N): combinational N-bit ripple adder built from fadder cells.
//   Ports: a, b, cin, sum, c_out, plus msb_ovf for the top slice.
//  adder_pipe: STAGES instances of add_slice in a generate loop, plus the stage
//   registers and handshake logic.
// TESTING
//  1. W=8,S=2: reset, then a=8'h0F b=8'h01 op=ADD cin=0
//     -> 2 cycles later out_valid=1, sum=8'h10, c_out=0, ovf=0.
//  2. W=8,S=2: 8'hFF+8'h01 cin=0 -> sum=8'h00, c_out=1, ovf=0.
//     8'h7F+8'h01 -> sum=8'h80, c_out=0, ovf=1.
//  3. W=8,S=2: SUB 8'h05-8'h07 cin=0 -> sum=8'hFE, c_out=0.
//     SUB 8'h80-8'h01 -> sum=8'h7F, ovf=1.
//  4. W=32,S=4: 100 back-to-back ops with out_ready=1
//     -> in_ready never drops; results in order, each matching the model, 4-cycle latency.
//  5. Backpressure: hold out_ready=0 for 5 cycles once the pipe is full
//     -> in_ready=0, sum stable; no loss or duplication after release. Randomise ready.
//  6. Assert reset with 3 ops in flight -> next cycle out_valid=0, in_ready=1;
//     no stale result ever appears.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared types and elaboration helpers for the pipelined add/subtract unit.
package adder_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } add_op_e;

    function automatic int unsigned slice_width(int unsigned width, int unsigned stages);
        return (stages == 0) ? width : width / stages;
    endfunction

    function automatic bit width_ok(int unsigned width, int unsigned stages);
        return (stages >= 1) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/adder_pipe_if.sv
// Operand/result handshake bundle of adder_pipe; slave is the adder's view.
interface adder_pipe_if
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    add_op_e          op;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;

    modport slave (
        input  in_valid, a, b, op, cin, out_ready,
        output in_ready, out_valid, sum, c_out, ovf
    );

    modport master (
        output in_valid, a, b, op, cin, out_ready,
        input  in_ready, out_valid, sum, c_out, ovf
    );

endinterface

// File: rtl/add_slice.sv
// Combinational N-bit ripple adder made of full-adder cells; msb_ovf is the
// signed-overflow flag, meaningful only when this is the top slice.
module add_slice #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         c_out,
    output logic         msb_ovf
);

    logic [N:0] carry;

    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = cin;
        for (int i = 0; i < int'(N); i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
        c_out   = carry[N];
        msb_ovf = (a[N-1] == b[N-1]) & (sum[N-1] != a[N-1]);
    end

endmodule

// File: rtl/adder_pipe.sv
// Pipelined add/subtract: one SLICE-bit slice per stage, carry registered between
// stages, valid/ready on both sides with a whole-pipe stall on output backpressure.
module adder_pipe
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input logic         clk,
    input logic         reset,
    adder_pipe_if.slave bus
);

    localparam int unsigned SLICE = slice_width(WIDTH, STAGES);

    if (!width_ok(WIDTH, STAGES)) begin : g_bad_params
        $error("adder_pipe: WIDTH must be a non-zero multiple of STAGES");
    end

    logic             stall;
    logic             valid_q [STAGES];
    logic             carry_q [STAGES];
    logic [WIDTH-1:0] res_q   [STAGES];
    logic [WIDTH-1:0] a_q     [STAGES];
    logic [WIDTH-1:0] b_q     [STAGES];
    logic             ovf_q;

    // Inputs seen by each stage: the ports for stage 0, the previous register otherwise.
    logic             st_valid [STAGES];
    logic             st_carry [STAGES];
    logic [WIDTH-1:0] st_res   [STAGES];
    logic [WIDTH-1:0] st_a     [STAGES];
    logic [WIDTH-1:0] st_b     [STAGES];

    logic [SLICE-1:0] sl_sum  [STAGES];
    logic             sl_cout [STAGES];
    logic             sl_ovf  [STAGES];

    assign stall        = bus.out_valid & ~bus.out_ready;
    assign bus.in_ready = ~stall;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            // SUB is a + ~b + ~cin: invert b and the borrow once on entry.
            assign st_valid[k] = bus.in_valid;
            assign st_carry[k] = (bus.op == OP_SUB) ? ~bus.cin : bus.cin;
            assign st_res[k]   = '0;
            assign st_a[k]     = bus.a;
            assign st_b[k]     = (bus.op == OP_SUB) ? ~bus.b : bus.b;
        end else begin : g_tail
            assign st_valid[k] = valid_q[k-1];
            assign st_carry[k] = carry_q[k-1];
            assign st_res[k]   = res_q[k-1];
            assign st_a[k]     = a_q[k-1];
            assign st_b[k]     = b_q[k-1];
        end

        add_slice #(
            .N(SLICE)
        ) u_slice (
            .a      (st_a[k][k*SLICE +: SLICE]),
            .b      (st_b[k][k*SLICE +: SLICE]),
            .cin    (st_carry[k]),
            .sum    (sl_sum[k]),
            .c_out  (sl_cout[k]),
            .msb_ovf(sl_ovf[k])
        );
    end

    // A stall freezes every stage, bubbles included, so ordering is trivially kept.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < int'(STAGES); k++) begin
                valid_q[k] <= 1'b0;
                carry_q[k] <= 1'b0;
                res_q[k]   <= '0;
                a_q[k]     <= '0;
                b_q[k]     <= '0;
            end
            ovf_q <= 1'b0;
        end else if (!stall) begin
            for (int k = 0; k < int'(STAGES); k++) begin
                valid_q[k]                  <= st_valid[k];
                carry_q[k]                  <= sl_cout[k];
                a_q[k]                      <= st_a[k];
                b_q[k]                      <= st_b[k];
                res_q[k]                    <= st_res[k];
                res_q[k][k*SLICE +: SLICE]  <= sl_sum[k];
            end
            ovf_q <= sl_ovf[STAGES-1];
        end
    end

    assign bus.out_valid = valid_q[STAGES-1];
    assign bus.sum       = res_q[STAGES-1];
    assign bus.c_out     = carry_q[STAGES-1];
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_adder_pipe.sv
// Bench for adder_pipe: directed 8-bit table (W=8,S=2) plus randomised 32-bit
// traffic (W=32,S=4) checked against an arithmetic reference with a result queue.
module tb_adder_pipe;
    import adder_pkg::*;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    int   cyc;

    adder_pipe_if #(.WIDTH(8))  if8 ();
    adder_pipe_if #(.WIDTH(32)) if32 ();

    adder_pipe #(.WIDTH(8), .STAGES(2)) dut8 (
        .clk  (clk),
        .reset(reset),
        .bus  (if8)
    );

    adder_pipe #(.WIDTH(32), .STAGES(4)) dut32 (
        .clk  (clk),
        .reset(reset),
        .bus  (if32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        string     name;
        logic [7:0] a;
        logic [7:0] b;
        add_op_e    op;
        logic       cin;
        logic [7:0] sum;
        logic       c;
        logic       v;
    } vec8_t;

    typedef struct {
        logic [31:0] sum;
        logic        c;
        logic        v;
        int          cyc;
    } res_t;

    localparam longint LIM = 64'sd2147483648;

    res_t sbq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic, borrow and signed range from first principles.
    function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                   input add_op_e op, input logic cin);
        res_t        r;
        logic [32:0] full;
        longint      sa, sbv, sr;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        if (op == OP_ADD) begin
            full = {1'b0, a} + {1'b0, b} + 33'(cin);
            sr   = sa + sbv + longint'(cin);
            r.c  = full[32];
        end else begin
            full = {1'b0, a} - {1'b0, b} - 33'(cin);
            sr   = sa - sbv - longint'(cin);
            r.c  = ~full[32];
        end
        r.sum = full[31:0];
        r.v   = (sr >= LIM) || (sr < -LIM);
        r.cyc = 0;
        return r;
    endfunction

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // One 32-bit cycle: drive after the edge, settle, then score both handshakes.
    task automatic step32(input bit iv, input bit ordy, input bit chk_lat);
        res_t e;
        @(posedge clk);
        #1;
        cyc++;
        if32.out_ready = ordy;
        if32.in_valid  = iv;
        if32.a         = rnd32();
        if32.b         = rnd32();
        if32.op        = add_op_e'($urandom_range(0, 1));
        if32.cin       = 1'($urandom_range(0, 1));
        #1;
        if (if32.out_valid && if32.out_ready) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out: got sum %0h expected no result", if32.sum);
            end else begin
                e = sbq.pop_front();
                chk("sum32", if32.sum, e.sum);
                chk("c_out32", 32'(if32.c_out), 32'(e.c));
                chk("ovf32", 32'(if32.ovf), 32'(e.v));
                if (chk_lat) chk("latency32", 32'(cyc - e.cyc), 32'd4);
            end
        end
        if (if32.in_valid && if32.in_ready) begin
            e     = model(if32.a, if32.b, if32.op, if32.cin);
            e.cyc = cyc;
            sbq.push_back(e);
        end
    endtask

    task automatic run8(input vec8_t v);
        int lat;
        @(posedge clk);
        #1;
        if8.in_valid  = 1'b1;
        if8.out_ready = 1'b1;
        if8.a         = v.a;
        if8.b         = v.b;
        if8.op        = v.op;
        if8.cin       = v.cin;
        @(posedge clk);
        #1;
        if8.in_valid = 1'b0;
        lat = 1;
        while (!if8.out_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({v.name, "_latency"}, 32'(lat), 32'd2);
        chk({v.name, "_sum"}, 32'(if8.sum), 32'(v.sum));
        chk({v.name, "_c_out"}, 32'(if8.c_out), 32'(v.c));
        chk({v.name, "_ovf"}, 32'(if8.ovf), 32'(v.v));
    endtask

    initial begin
        vec8_t vecs[8];
        logic [31:0] held;

        total = 0;
        bad   = 0;
        cyc   = 0;
        vecs[0] = '{"add_0f_01",  8'h0F, 8'h01, OP_ADD, 1'b0, 8'h10, 1'b0, 1'b0};
        vecs[1] = '{"add_ff_01",  8'hFF, 8'h01, OP_ADD, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{"add_7f_01",  8'h7F, 8'h01, OP_ADD, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[3] = '{"sub_05_07",  8'h05, 8'h07, OP_SUB, 1'b0, 8'hFE, 1'b0, 1'b0};
        vecs[4] = '{"sub_80_01",  8'h80, 8'h01, OP_SUB, 1'b0, 8'h7F, 1'b1, 1'b1};
        vecs[5] = '{"add_80_80c", 8'h80, 8'h80, OP_ADD, 1'b1, 8'h01, 1'b1, 1'b1};
        vecs[6] = '{"sub_10_0fb", 8'h10, 8'h0F, OP_SUB, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[7] = '{"sub_00_00",  8'h00, 8'h00, OP_SUB, 1'b0, 8'h00, 1'b1, 1'b0};

        reset = 1'b1;
        if8.in_valid = 1'b0;  if8.out_ready = 1'b0;
        if8.a = '0; if8.b = '0; if8.op = OP_ADD; if8.cin = 1'b0;
        if32.in_valid = 1'b0; if32.out_ready = 1'b0;
        if32.a = '0; if32.b = '0; if32.op = OP_ADD; if32.cin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("rst_out_valid8", 32'(if8.out_valid), 32'd0);
        chk("rst_in_ready8", 32'(if8.in_ready), 32'd1);
        chk("rst_sum8", 32'(if8.sum), 32'd0);
        chk("rst_c_out8", 32'(if8.c_out), 32'd0);
        chk("rst_ovf8", 32'(if8.ovf), 32'd0);
        chk("rst_out_valid32", 32'(if32.out_valid), 32'd0);
        chk("rst_in_ready32", 32'(if32.in_ready), 32'd1);
        chk("rst_sum32", if32.sum, 32'd0);

        for (int i = 0; i < 8; i++) run8(vecs[i]);

        // Back-to-back with no backpressure: full rate and fixed latency.
        for (int i = 0; i < 100; i++) begin
            step32(1'b1, 1'b1, 1'b1);
            chk("in_ready_stream", 32'(if32.in_ready), 32'd1);
        end
        for (int i = 0; i < 8; i++) step32(1'b0, 1'b1, 1'b1);

        // Fill the pipe, then hold out_ready low for 5 cycles.
        for (int i = 0; i < 6; i++) step32(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step32(1'b1, 1'b0, 1'b0);
            if (i == 0) held = if32.sum;
            chk("stall_out_valid", 32'(if32.out_valid), 32'd1);
            chk("stall_in_ready", 32'(if32.in_ready), 32'd0);
            chk("stall_sum_hold", if32.sum, held);
        end
        for (int i = 0; i < 400; i++)
            step32($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, 1'b0);
        for (int i = 0; i < 60 && sbq.size() != 0; i++) step32(1'b0, 1'b1, 1'b0);
        chk("drain_empty", 32'(sbq.size()), 32'd0);
        step32(1'b0, 1'b1, 1'b0);
        chk("drain_out_valid", 32'(if32.out_valid), 32'd0);

        // Reset with three operations in flight.
        for (int i = 0; i < 3; i++) step32(1'b1, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        reset         = 1'b1;
        if32.in_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sbq.delete();
        #1;
        chk("midrst_out_valid", 32'(if32.out_valid), 32'd0);
        chk("midrst_in_ready", 32'(if32.in_ready), 32'd1);
        for (int i = 0; i < 8; i++) begin
            step32(1'b0, 1'b1, 1'b0);
            chk("no_stale", 32'(if32.out_valid), 32'd0);
        end
        for (int i = 0; i < 20; i++) step32(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) step32(1'b0, 1'b1, 1'b1);
        chk("final_empty", 32'(sbq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
